// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin or fixed-priority grant, then a single
// memory access (or read-modify-write for sub-word stores) with a one-cycle done pulse.
module dmem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_cs_n,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACC, RMW_RD, RMW_WR, DONE} state_t;

    state_t      state_reg;
    logic        last_reg;
    logic        port_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  done_reg;
    logic [1:0]  err_reg;
    logic [31:0] rdata_reg [2];
    logic        mem_rd_reg;
    logic        mem_wr_reg;
    logic        mem_cs_n_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic        pick1;
    logic        gnt_any;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic [31:0] word);
        case (size)
            2'b00:   load_fmt = {24'b0, word[7:0]};
            2'b01:   load_fmt = {16'b0, word[15:0]};
            default: load_fmt = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [1:0] size, input logic [31:0] word,
                                          input logic [31:0] data);
        case (size)
            2'b00:   merge = {word[31:8], data[7:0]};
            2'b01:   merge = {word[31:16], data[15:0]};
            default: merge = data;
        endcase
    endfunction

    // last_reg holds the port granted most recently; port 1 wins a tie only after port 0 went last.
    always_comb begin
        pick1 = 1'b0;
        if (m1_req && (!m0_req || (RR_EN && !last_reg))) begin
            pick1 = 1'b1;
        end
    end

    assign gnt_any   = rst && (state_reg == IDLE) && (m0_req || m1_req);
    assign m0_gnt    = gnt_any && !pick1;
    assign m1_gnt    = gnt_any && pick1;
    assign sel_we    = pick1 ? m1_we    : m0_we;
    assign sel_size  = pick1 ? m1_size  : m0_size;
    assign sel_addr  = pick1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick1 ? m1_wdata : m0_wdata;

    assign m0_done   = done_reg[0];
    assign m1_done   = done_reg[1];
    assign m0_err    = err_reg[0];
    assign m1_err    = err_reg[1];
    assign m0_rdata  = rdata_reg[0];
    assign m1_rdata  = rdata_reg[1];
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_cs_n  = mem_cs_n_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Memory strobes are registered on entry to each access state, so a reset
    // before the write-cycle edge can never let a store reach memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            port_reg      <= 1'b0;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            done_reg      <= '0;
            err_reg       <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_cs_n_reg  <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            done_reg      <= '0;
            err_reg       <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_cs_n_reg  <= 1'b1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (gnt_any) begin
                        last_reg  <= pick1;
                        port_reg  <= pick1;
                        we_reg    <= sel_we;
                        size_reg  <= sel_size;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        if (sel_size == 2'b11) begin
                            state_reg       <= DONE;
                            done_reg[pick1] <= 1'b1;
                            err_reg[pick1]  <= 1'b1;
                        end else if (sel_we && sel_size != 2'b10) begin
                            state_reg    <= RMW_RD;
                            mem_rd_reg   <= 1'b1;
                            mem_cs_n_reg <= 1'b0;
                            mem_addr_reg <= sel_addr;
                        end else begin
                            state_reg    <= ACC;
                            mem_cs_n_reg <= 1'b0;
                            mem_addr_reg <= sel_addr;
                            if (sel_we) begin
                                mem_wr_reg    <= 1'b1;
                                mem_wdata_reg <= sel_wdata;
                            end else begin
                                mem_rd_reg <= 1'b1;
                            end
                        end
                    end
                end
                ACC: begin
                    state_reg          <= DONE;
                    done_reg[port_reg] <= 1'b1;
                    if (!we_reg) begin
                        rdata_reg[port_reg] <= load_fmt(size_reg, mem_rdata);
                    end
                end
                RMW_RD: begin
                    state_reg     <= RMW_WR;
                    mem_wr_reg    <= 1'b1;
                    mem_cs_n_reg  <= 1'b0;
                    mem_addr_reg  <= addr_reg;
                    mem_wdata_reg <= merge(size_reg, mem_rdata, wdata_reg);
                end
                RMW_WR: begin
                    state_reg          <= DONE;
                    done_reg[port_reg] <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
